// File: rtl/dadda_pkg.sv
// dadda_pkg: Dadda height sequence, level/latency helpers and column-height types
// shared by dadda_pipe_tree and dadda_level.
package dadda_pkg;
  localparam int MAX_COLS = 64;
  typedef logic [7:0] height_t;
  typedef logic [MAX_COLS*8-1:0] heights_t;
  function automatic int dadda_d(input int j);
    int d = 2;
    for (int i = 1; i < j; i++) d = d * 3 / 2;
    return d;
  endfunction
  function automatic int num_levels(input int n);
    int l = 0;
    while (dadda_d(l + 1) < n) l++;
    return l;
  endfunction
  function automatic int level_target(input int n, input int lvl);
    return dadda_d(num_levels(n) - lvl);
  endfunction
  function automatic int latency(input int levels, input int reg_every);
    return levels == 0 ? 1 : (levels + reg_every - 1) / reg_every;
  endfunction
  // Minimal-adder rule: each column sheds exactly its excess over d, carries ripple into the next column.
  function automatic int col_add(input heights_t h, input int d, input int c, input bit ha);
    int ci = 0;
    int ex = 0;
    int fa = 0;
    int hc = 0;
    for (int i = 0; i <= c; i++) begin
      ex = int'(h[i*8 +: 8]) + ci - d;
      fa = ex > 0 ? ex / 2 : 0;
      hc = ex > 0 ? ex % 2 : 0;
      ci = fa + hc;
    end
    return ha ? hc : fa;
  endfunction
  function automatic int col_cin(input heights_t h, input int d, input int c);
    return col_add(h, d, c - 1, 1'b0) + col_add(h, d, c - 1, 1'b1);
  endfunction
  function automatic heights_t heights_at(input int n, input int w, input int lvl);
    heights_t h = '0;
    heights_t o;
    int d;
    int t;
    for (int c = 0; c < w; c++) h[c*8 +: 8] = height_t'(n);
    for (int l = 0; l < lvl; l++) begin
      d = level_target(n, l);
      o = '0;
      for (int c = 0; c < w; c++) begin
        t = int'(h[c*8 +: 8]) + col_cin(h, d, c);
        o[c*8 +: 8] = height_t'(t < d ? t : d);
      end
      h = o;
    end
    return h;
  endfunction
endpackage

// File: rtl/dadda_level.sv
// dadda_level: one combinational Dadda level; column c holds its bits at [c*MAXH +: MAXH],
// packed from bit 0 upward, and leaves with at most D bits.
module dadda_level import dadda_pkg::*; #(
  parameter int W = 11,
  parameter int MAXH = 8,
  parameter int D = 6,
  parameter heights_t HIN = '0
) (
  input  logic [W*MAXH-1:0] i_bits,
  output logic [W*MAXH-1:0] o_bits
);
  logic [MAXH-1:0] w_cy [W];
  for (genvar c = 0; c < W; c++) begin : g_col
    localparam int H = int'(HIN[c*8 +: 8]);
    localparam int FA = col_add(HIN, D, c, 1'b0);
    localparam int HA = col_add(HIN, D, c, 1'b1);
    localparam int CI = col_cin(HIN, D, c);
    localparam int P = H - 3 * FA - 2 * HA;
    logic [MAXH-1:0] w_col, w_cin, w_s, w_c, w_o;
    assign w_col = i_bits[c*MAXH +: MAXH];
    if (c == 0) begin : g_c0
      assign w_cin = '0;
    end else begin : g_cn
      assign w_cin = w_cy[c-1];
    end
    // Output column order: adder sums, untouched bits, then carries from the column below.
    always_comb begin
      w_s = '0;
      w_c = '0;
      w_o = '0;
      for (int k = 0; k < FA; k++) begin
        w_s[k] = w_col[3*k] ^ w_col[3*k+1] ^ w_col[3*k+2];
        w_c[k] = (w_col[3*k] & w_col[3*k+1]) | (w_col[3*k+2] & (w_col[3*k] ^ w_col[3*k+1]));
      end
      for (int k = 0; k < HA; k++) begin
        w_s[FA+k] = w_col[3*FA+2*k] ^ w_col[3*FA+2*k+1];
        w_c[FA+k] = w_col[3*FA+2*k] & w_col[3*FA+2*k+1];
      end
      for (int k = 0; k < FA + HA; k++) w_o[k] = w_s[k];
      for (int k = 0; k < P; k++) w_o[FA+HA+k] = w_col[3*FA+2*HA+k];
      for (int k = 0; k < CI; k++) w_o[FA+HA+P+k] = w_cin[k];
    end
    assign w_cy[c] = w_c;
    assign o_bits[c*MAXH +: MAXH] = w_o;
  end
endmodule

// File: rtl/dadda_pipe_tree.sv
// dadda_pipe_tree: pipelined Dadda carry-save compressor of NUM_OPS operands.
// Define DADDA_FINAL_CPA_EN to add a registered carry-propagate adder driving sum.
module dadda_pipe_tree import dadda_pkg::*; #(
  parameter int NUM_OPS = 8,
  parameter int IN_W = 8,
  parameter int OUT_W = 11,
  parameter int REG_EVERY = 2,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_OPS*IN_W-1:0] in_ops,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        vector0,
  output logic [OUT_W-1:0]        vector1
`ifdef DADDA_FINAL_CPA_EN
  ,
  output logic [OUT_W-1:0]        sum
`endif
);
  localparam int LEVELS = num_levels(NUM_OPS);
  localparam int S = latency(LEVELS, REG_EVERY);
  localparam int MW = OUT_W * NUM_OPS;
  localparam int LN = LEVELS > 0 ? LEVELS : 1;
  logic [MW-1:0] w_mat, w_lin [LN], w_lout [LN], w_sin [S], r_st [S];
  logic [S-1:0] r_vld;
  logic [S:0] w_vin;
  logic [OUT_W-1:0] w_v0, w_v1;
  logic w_last, w_en;
  always_comb begin
    logic [OUT_W-1:0] e;
    w_mat = '0;
    e = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      e = SIGNED != 0 ? OUT_W'($signed(in_ops[k*IN_W +: IN_W])) : OUT_W'(in_ops[k*IN_W +: IN_W]);
      for (int c = 0; c < OUT_W; c++) w_mat[c*NUM_OPS+k] = e[c];
    end
  end
  for (genvar l = 0; l < LEVELS; l++) begin : g_lv
    if (l == 0) begin : g_i
      assign w_lin[l] = w_mat;
    end else if (l % REG_EVERY == 0) begin : g_r
      assign w_lin[l] = r_st[l/REG_EVERY-1];
    end else begin : g_c
      assign w_lin[l] = w_lout[l-1];
    end
    dadda_level #(
      .W(OUT_W), .MAXH(NUM_OPS), .D(level_target(NUM_OPS, l)), .HIN(heights_at(NUM_OPS, OUT_W, l))
    ) u_lv (.i_bits(w_lin[l]), .o_bits(w_lout[l]));
  end
  for (genvar s = 0; s < S; s++) begin : g_st
    if (LEVELS == 0) begin : g_0
      assign w_sin[s] = w_mat;
    end else begin : g_l
      assign w_sin[s] = w_lout[((s+1)*REG_EVERY < LEVELS ? (s+1)*REG_EVERY : LEVELS) - 1];
    end
  end
  assign w_en = !(w_last && !out_ready);
  assign in_ready = w_en;
  assign out_valid = w_last;
  assign w_vin = {r_vld, in_valid};
  // Stage data only loads with a valid word so bubbles leave the last result in place.
  always_ff @(posedge clk)
    if (rst) begin
      r_vld <= '0;
      for (int s = 0; s < S; s++) r_st[s] <= '0;
    end else if (w_en) begin
      r_vld <= w_vin[S-1:0];
      for (int s = 0; s < S; s++) if (w_vin[s]) r_st[s] <= w_sin[s];
    end
  always_comb begin
    w_v0 = '0;
    w_v1 = '0;
    for (int c = 0; c < OUT_W; c++) begin
      w_v0[c] = r_st[S-1][c*NUM_OPS];
      w_v1[c] = r_st[S-1][c*NUM_OPS+1];
    end
  end
`ifdef DADDA_FINAL_CPA_EN
  logic r_cv;
  logic [OUT_W-1:0] r_v0, r_v1, r_sum;
  always_ff @(posedge clk)
    if (rst) begin
      r_cv <= 1'b0;
      r_v0 <= '0;
      r_v1 <= '0;
      r_sum <= '0;
    end else if (w_en) begin
      r_cv <= r_vld[S-1];
      if (r_vld[S-1]) begin
        r_v0 <= w_v0;
        r_v1 <= w_v1;
        r_sum <= w_v0 + w_v1;
      end
    end
  assign w_last = r_cv;
  assign vector0 = r_v0;
  assign vector1 = r_v1;
  assign sum = r_sum;
`else
  assign w_last = r_vld[S-1];
  assign vector0 = w_v0;
  assign vector1 = w_v1;
`endif
endmodule

// File: doc/dadda_pipe_tree.md
DADDA_PIPE_TREE -- requirements
Module: dadda_pipe_tree

Interface
REQ-001 SHALL have parameter NUM_OPS, default 8, number of operands compressed (legal 2..32).
REQ-002 SHALL have parameter IN_W, default 8, width of each operand in bits.
REQ-003 SHALL have parameter OUT_W, default 11, width of the result vectors in bits.
REQ-004 SHALL have parameter REG_EVERY, default 2, the number of Dadda reduction levels between pipeline registers (legal 1..8).
REQ-005 SHALL have parameter SIGNED, default 0; 1 sign-extends the operands, 0 zero-extends them.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, operand set valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts an operand set this cycle.
REQ-010 SHALL have port in_ops, input, NUM_OPS*IN_W, operands packed; operand k occupies bits [k*IN_W +: IN_W].
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have port vector0, output, OUT_W, carry-save sum word.
REQ-014 SHALL have port vector1, output, OUT_W, carry-save carry word.
REQ-015 SHALL have port sum, output, OUT_W, resolved sum; present only under DADDA_FINAL_CPA_EN.

Function
REQ-016 SHALL reduce the operands through LEVELS Dadda levels, with heights d1=2, d(j+1)=floor(1.5*dj).
REQ-017 LEVELS SHALL be the count of dj strictly below NUM_OPS; NUM_OPS=2 gives 0 levels.
REQ-018 Each level SHALL reduce every column to at most dj bits using only full adders (3:2) and half adders (2:2), applied with the minimal-adder Dadda rule.
REQ-019 SHALL extend each operand to OUT_W bits according to SIGNED before reduction.
REQ-020 SHALL discard bits at weight 2^OUT_W and above, so that (vector0+vector1) mod 2^OUT_W equals the operand sum mod 2^OUT_W.
REQ-021 SHALL insert a register stage after every REG_EVERY levels and after the final level.
REQ-022 Latency L SHALL be max(1, ceil(LEVELS/REG_EVERY)) cycles from the in_valid&&in_ready handshake to out_valid.
REQ-023 A transfer SHALL occur on a cycle with in_valid&&in_ready, or with out_valid&&out_ready.
REQ-024 Each pipeline stage SHALL carry its own valid bit.
REQ-025 The pipeline SHALL stall as a whole when out_valid=1 and out_ready=0.
REQ-026 in_ready SHALL equal the negation of the stall condition (combinational).
REQ-027 During a stall, all stage data and valid bits SHALL hold, and vector0/vector1/sum SHALL remain stable.
REQ-028 Simultaneous input acceptance and output drain SHALL both take effect in the same cycle, sustaining one result per cycle.
REQ-029 Bubbles (in_valid=0) SHALL propagate as invalid stages; no result is duplicated or dropped.

Reset
REQ-030 On rst=1 at a clock edge, all stage valid bits SHALL clear, so out_valid=0.
REQ-031 On reset, vector0, vector1 and sum SHALL be driven to 0.
REQ-032 A reset mid-operation SHALL discard all in-flight operand sets.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-034 Macro DADDA_FINAL_CPA_EN defined: SHALL add one registered carry-propagate adder stage, so L becomes L+1.
REQ-035 With DADDA_FINAL_CPA_EN, sum SHALL equal (vector0+vector1) mod 2^OUT_W, and vector0/vector1 SHALL be delayed to align with sum.
REQ-036 Without DADDA_FINAL_CPA_EN: port sum SHALL be absent, latency SHALL be as in REQ-022, and no CPA logic SHALL exist.

Structure
REQ-037 Package dadda_pkg SHALL hold the height-sequence function, the LEVELS computation, the latency computation, and the column-height typedefs.
REQ-038 Sub-module dadda_level SHALL implement one combinational reduction level, parametrised by target height and column heights.
REQ-039 dadda_pipe_tree SHALL instantiate dadda_level per level via generate, with registers inserted per REQ-021.

Verification (NUM_OPS=8, IN_W=8, OUT_W=11, REG_EVERY=2, macro off, so LEVELS=4, L=2)
REQ-040 All operands 0xFF, out_ready=1 -> out_valid exactly 2 cycles after the handshake, with vector0+vector1 mod 2^11 = 0x7F8.
REQ-041 SIGNED=1, all operands 0x80 -> vector0+vector1 mod 2^11 = 0x400 (-1024).
REQ-042 OUT_W=10, all operands 0xFF -> vector0+vector1 mod 2^10 = 0x3F8 (truncation).
REQ-043 Back-to-back stream of 20 random sets, out_ready held 0 for cycles 5..9 -> in_ready=0 for those cycles, outputs stable, all 20 results in order with no loss or duplication.
REQ-044 rst asserted with 2 sets in flight -> out_valid=0 and outputs 0 the next cycle; no stale result ever emerges.
REQ-045 DADDA_FINAL_CPA_EN defined, all operands 0x01 -> sum=0x008 at latency 3, with vector0+vector1=0x008 aligned to sum.
